mips_run_control: RTL
=====================

// Module: mips_run_control
// PURPOSE
// - Synthesizable run controller wrapped around the MIPS 32-bit core (MIPS_32Bit_Wrapper).
// - Sequences core reset, gates the core clock enable, counts executed cycles,
//   supports free-run and single-step modes, and detects halt conditions.
// - Halt conditions: halt opcode, PC stuck in a loop, or a cycle budget.
// - Generalised, parametrised replacement for fixed-delay reset and fixed-time stop.
// PARAMETERS
// - RST_STRETCH   4            core reset hold, in clk cycles (>=1)
// - CYCLE_W       32           width of cycle_count
// - MAX_CYCLES    62           cycle budget; 0 disables the budget halt
// - PC_W          32           PC width
// - HALT_INSTR    32'h0000000C instruction word that halts the core (syscall)
// - STABLE_CYCLES 2            consecutive repeated-PC enabled cycles that halt the core (>=1)
// PORTS
// - clk          in   1        system clock
// - reset_n      in   1        async active-low reset
// - restart      in   1        1-cycle pulse: re-enter HOLD and clear all state
// - step_mode    in   1        1 = single-step, 0 = free run
// - step         in   1        level input; each rising edge grants one core cycle in STEP
// - pc           in   PC_W     current core PC
// - instr        in   32       instruction at pc
// - core_reset_n out  1        registered active-low reset to the core
// - core_clk_en  out  1        combinational; core state advances only when 1
// - running      out  1        state is RUN or STEP
// - halted       out  1        state is HALT
// - halt_cause   out  3        000 none, 001 instr, 010 loop, 011 budget, 100 breakpoint
// - cycle_count  out  CYCLE_W  number of enabled cycles, saturating
// BEHAVIOUR
// - Clock is clk. Reset is asynchronous, active-low, on reset_n.
// - Reset values: state HOLD, core_reset_n=0, core_clk_en=0, running=0, halted=0,
//   halt_cause=000, cycle_count=0, hold_cnt=0, stable_cnt=0, pc_valid=0, step_q=0.
// - HOLD: core_reset_n=0. hold_cnt counts up to RST_STRETCH-1.
//   - On that edge: core_reset_n<=1.
//   - Next state is STEP if step_mode=1, else RUN.
// - RUN: core_clk_en=1. Moves to STEP when step_mode=1 is sampled.
// - STEP: core_clk_en = step & ~step_q. step_q is registered every cycle in all states.
//   - Moves to RUN when step_mode=0 is sampled.
// - Enabled cycle (core_clk_en=1):
//   - cycle_count+1, saturating at all-ones.
//   - pc_valid<=1. The PC of the previous enabled cycle is registered.
//   - stable_cnt: +1 if pc_valid and pc equals the previous enabled PC; otherwise 0.
// - Halt checks run on enabled cycles only, in priority order:
//   - instr==HALT_INSTR -> cause 001
//   - stable_cnt+1 == STABLE_CYCLES -> cause 010
//   - MAX_CYCLES!=0 and cycle_count == MAX_CYCLES-1 -> cause 011
//   - Any hit: next state HALT. The halting instruction itself completes (clk_en was 1).
// - HALT: core_clk_en=0, halted=1. halt_cause and cycle_count are held until restart.
// - restart (any state) wins over every halt or step event. It clears:
//   cycle_count, halt_cause, hold_cnt, stable_cnt, pc_valid. Next state HOLD, core_reset_n<=0.
// - reset_n low mid-operation: all outputs go to reset values immediately (async).
// CONFIGURATION
// - Macro MIPS_RUN_CTRL_BREAKPOINT_EN defined adds three ports:
//   - bp_en   in  1     breakpoint enable
//   - bp_addr in  PC_W  breakpoint address
//   - halt_pc out PC_W  PC captured on entry to HALT; reset value 0
// - Breakpoint behaviour:
//   - In RUN/STEP, bp_en & pc==bp_addr forces core_clk_en=0 that cycle.
//   - Next state HALT, cause 100.
//   - The instruction at bp_addr does not execute.
//   - Breakpoint has priority over all other causes.
// - Macro undefined: no extra ports, cause 100 never produced.
// TESTING
// - reset_n low 20 ns then high, RST_STRETCH=4 -> core_reset_n rises at 4th clk edge;
//   core_clk_en=1 from the next cycle.
// - instr=32'h0000000C on 10th enabled cycle -> halted=1, halt_cause=001, cycle_count=10;
//   core_clk_en=0 thereafter.
// - pc held at 0x0000_0040 (branch-to-self) -> halt_cause=010 after 2 repeated enabled
//   cycles, STABLE_CYCLES=2.
// - No halt opcode or loop, MAX_CYCLES=62 -> halted with cycle_count=62, halt_cause=011.
// - step_mode=1, 3 step pulses -> exactly 3 core_clk_en cycles, cycle_count=3.
//   A held step level grants only 1 cycle.
// - Mid-operation and breakpoint:
//   - reset_n low mid-RUN -> all outputs at reset values before the next clk.
//   - restart in HALT -> HOLD, counters cleared.
//   - With macro, bp_addr=0x0000_0008 -> halt_cause=100, halt_pc=0x0000_0008.

Source files
------------

// File: rtl/mips_run_control_if.sv
// Run-control bundle between the MIPS core harness and mips_run_control.
// Breakpoint signals exist only with MIPS_RUN_CTRL_BREAKPOINT_EN defined.
interface mips_run_control_if #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned CYCLE_W = 32
);
    logic               restart;
    logic               step_mode;
    logic               step;
    logic [PC_W-1:0]    pc;
    logic [31:0]        instr;
    logic               core_reset_n;
    logic               core_clk_en;
    logic               running;
    logic               halted;
    logic [2:0]         halt_cause;
    logic [CYCLE_W-1:0] cycle_count;
`ifdef MIPS_RUN_CTRL_BREAKPOINT_EN
    logic               bp_en;
    logic [PC_W-1:0]    bp_addr;
    logic [PC_W-1:0]    halt_pc;

    modport master (
        output restart, step_mode, step, pc, instr, bp_en, bp_addr,
        input  core_reset_n, core_clk_en, running, halted,
        input  halt_cause, cycle_count, halt_pc
    );
    modport slave (
        input  restart, step_mode, step, pc, instr, bp_en, bp_addr,
        output core_reset_n, core_clk_en, running, halted,
        output halt_cause, cycle_count, halt_pc
    );
`else
    modport master (
        output restart, step_mode, step, pc, instr,
        input  core_reset_n, core_clk_en, running, halted,
        input  halt_cause, cycle_count
    );
    modport slave (
        input  restart, step_mode, step, pc, instr,
        output core_reset_n, core_clk_en, running, halted,
        output halt_cause, cycle_count
    );
`endif
endinterface

// File: rtl/mips_run_control.sv
// Run controller for the MIPS core: reset stretch, clock gating, cycle count, halts.
// Define MIPS_RUN_CTRL_BREAKPOINT_EN to add the PC breakpoint (cause 100, halt_pc).
module mips_run_control #(
    parameter int unsigned RST_STRETCH   = 4,
    parameter int unsigned CYCLE_W       = 32,
    parameter int unsigned MAX_CYCLES    = 62,
    parameter int unsigned PC_W          = 32,
    parameter logic [31:0] HALT_INSTR    = 32'h0000000C,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input logic               clk,
    input logic               reset_n,
    mips_run_control_if.slave bus
);
    localparam int unsigned HW = $clog2(RST_STRETCH) + 1;
    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1) + 1;
    localparam logic [2:0] C_NONE   = 3'b000;
    localparam logic [2:0] C_INSTR  = 3'b001;
    localparam logic [2:0] C_LOOP   = 3'b010;
    localparam logic [2:0] C_BUDGET = 3'b011;

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_STEP, S_HALT} state_e;

    state_e             state_q, state_d;
    logic               core_rst_q, core_rst_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [CYCLE_W-1:0] count_q, count_d;
    logic [2:0]         cause_q, cause_d;
    logic [SW-1:0]      stable_q, stable_d, stable_inc;
    logic               pcv_q, pcv_d;
    logic [PC_W-1:0]    prev_pc_q, prev_pc_d;
    logic               step_q;
    logic               clk_en, bp_hit, repeat_pc, halt_hit;
    logic [2:0]         hit_cause;
`ifdef MIPS_RUN_CTRL_BREAKPOINT_EN
    localparam logic [2:0] C_BP = 3'b100;
    logic [PC_W-1:0]    halt_pc_q, halt_pc_d;
`endif

    always_comb begin
        state_d    = state_q;
        core_rst_d = core_rst_q;
        hold_d     = hold_q;
        count_d    = count_q;
        cause_d    = cause_q;
        stable_d   = stable_q;
        pcv_d      = pcv_q;
        prev_pc_d  = prev_pc_q;
        clk_en     = 1'b0;
        halt_hit   = 1'b0;
        hit_cause  = C_NONE;
        bp_hit     = 1'b0;
        repeat_pc  = pcv_q && (bus.pc == prev_pc_q);
        stable_inc = stable_q + SW'(1);
`ifdef MIPS_RUN_CTRL_BREAKPOINT_EN
        halt_pc_d  = halt_pc_q;
        bp_hit     = (state_q == S_RUN || state_q == S_STEP) &&
                     bus.bp_en && (bus.pc == bus.bp_addr);
`endif

        unique case (state_q)
            S_HOLD: begin
                if (hold_q == HW'(RST_STRETCH - 1)) begin
                    core_rst_d = 1'b1;
                    state_d    = bus.step_mode ? S_STEP : S_RUN;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_RUN: begin
                clk_en = ~bp_hit;
                if (bus.step_mode) state_d = S_STEP;
            end
            S_STEP: begin
                clk_en = bus.step & ~step_q & ~bp_hit;
                if (!bus.step_mode) state_d = S_RUN;
            end
            S_HALT: ;
            default: state_d = S_HOLD;
        endcase

        // a restart in the same cycle suppresses the grant
        clk_en = clk_en & ~bus.restart;

        if (clk_en) begin
            count_d   = (&count_q) ? count_q : count_q + CYCLE_W'(1);
            pcv_d     = 1'b1;
            prev_pc_d = bus.pc;
            stable_d  = repeat_pc ? stable_inc : '0;
            if (bus.instr == HALT_INSTR) begin
                halt_hit  = 1'b1;
                hit_cause = C_INSTR;
            end else if (repeat_pc && stable_inc == SW'(STABLE_CYCLES)) begin
                halt_hit  = 1'b1;
                hit_cause = C_LOOP;
            end else if (MAX_CYCLES != 0 &&
                         count_q == CYCLE_W'(MAX_CYCLES - 1)) begin
                halt_hit  = 1'b1;
                hit_cause = C_BUDGET;
            end
        end

`ifdef MIPS_RUN_CTRL_BREAKPOINT_EN
        if (bp_hit) begin
            halt_hit  = 1'b1;
            hit_cause = C_BP;
        end
`endif

        if (bus.restart) begin
            state_d    = S_HOLD;
            core_rst_d = 1'b0;
            hold_d     = '0;
            count_d    = '0;
            cause_d    = C_NONE;
            stable_d   = '0;
            pcv_d      = 1'b0;
        end else if (halt_hit) begin
            state_d = S_HALT;
            cause_d = hit_cause;
`ifdef MIPS_RUN_CTRL_BREAKPOINT_EN
            halt_pc_d = bus.pc;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_HOLD;
            core_rst_q <= 1'b0;
            hold_q     <= '0;
            count_q    <= '0;
            cause_q    <= C_NONE;
            stable_q   <= '0;
            pcv_q      <= 1'b0;
            prev_pc_q  <= '0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_rst_q <= core_rst_d;
            hold_q     <= hold_d;
            count_q    <= count_d;
            cause_q    <= cause_d;
            stable_q   <= stable_d;
            pcv_q      <= pcv_d;
            prev_pc_q  <= prev_pc_d;
            step_q     <= bus.step;
        end
    end

`ifdef MIPS_RUN_CTRL_BREAKPOINT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) halt_pc_q <= '0;
        else          halt_pc_q <= halt_pc_d;
    end

    assign bus.halt_pc = halt_pc_q;
`endif

    assign bus.core_reset_n = core_rst_q;
    assign bus.core_clk_en  = clk_en;
    assign bus.running      = (state_q == S_RUN) || (state_q == S_STEP);
    assign bus.halted       = (state_q == S_HALT);
    assign bus.halt_cause   = cause_q;
    assign bus.cycle_count  = count_q;
endmodule
